fb_port_arbiter: RTL

- Owns the single port of the 640x480 3-bit-per-pixel frame-buffer BRAM and shares it between two users: the display read path, which supplies a forecast read address, and the drawing engine, which writes pixel codes.
- After reset it clears the whole buffer to code 0, then asserts ready to release the display path.
- Drawing writes are queued in a small FIFO and retired only while the display path does not need the port.

---
 rtl/fb_port_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: clears the BRAM after reset, then gives the display forecast
// priority and retires queued drawing writes outside the display window. Option: FB_DROP_COUNT_EN.
module fb_port_arbiter #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 3,
    parameter int unsigned PIXELS     = 307200,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned V_TOTAL    = 525,
    parameter int unsigned PREFETCH   = 4,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    output logic              ready
`ifdef FB_DROP_COUNT_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  H_PRE_C    = CNT_W'(H_TOTAL - PREFETCH);
    localparam logic [CNT_W-1:0]  H_TOT_C    = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0]  V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  V_LAST_C   = CNT_W'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] PIX_C      = ADDR_W'(PIXELS);
    localparam logic [ADDR_W-1:0] PIX_LAST_C = ADDR_W'(PIXELS - 1);
    localparam logic [OCC_W-1:0]  DEPTH_C    = OCC_W'(FIFO_DEPTH);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    wr_entry_t         fifo_mem [FIFO_DEPTH];
    wr_entry_t         head_c;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_din_q, bram_din_d;
    logic              bram_we_q, bram_we_d;
    logic              ready_q, ready_d;
    logic              wr_full_q, wr_full_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              in_window_c, push_c, pop_c, oor_c;

    assign head_c = fifo_mem[rd_ptr_q];
    assign push_c = wr_req && !wr_full_q;

    // Port is reserved for the display during active video plus the prefetch lead-in of each line.
    always_comb begin
        in_window_c = 1'b0;
        if (hcount < H_TOT_C) begin
            if ((vcount < V_ACT_C) && ((hcount < H_ACT_C) || (hcount >= H_PRE_C)))
                in_window_c = 1'b1;
            if ((vcount == V_LAST_C) && (hcount >= H_PRE_C))
                in_window_c = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        bram_we_d   = 1'b0;
        ready_d     = ready_q;
        pop_c       = 1'b0;
        oor_c       = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                bram_we_d   = 1'b1;
                bram_din_d  = '0;
                bram_addr_d = clr_cnt_q;
                if (clr_cnt_q == PIX_LAST_C)
                    state_d = ST_RUN;
                else
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
            ST_RUN: begin
                ready_d = 1'b1;
                if (in_window_c) begin
                    bram_addr_d = rd_addr;
                end else if (occ_q != '0) begin
                    pop_c       = 1'b1;
                    bram_addr_d = head_c.addr;
                    bram_din_d  = head_c.data;
                    bram_we_d   = (head_c.addr < PIX_C);
                    oor_c       = (head_c.addr >= PIX_C);
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Simultaneous push and pop leave occupancy and the full flag untouched.
    always_comb begin
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        case ({push_c, pop_c})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        wr_full_d = (occ_d == DEPTH_C);
    end

    always_ff @(posedge clock) begin
        if (push_c)
            fifo_mem[wr_ptr_q] <= '{addr: wr_addr, data: wr_data};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_we_q   <= 1'b0;
            ready_q     <= 1'b0;
            wr_full_q   <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            bram_we_q   <= bram_we_d;
            ready_q     <= ready_d;
            wr_full_q   <= wr_full_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
        end
    end

    assign wr_full   = wr_full_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;
    assign bram_we   = bram_we_q;
    assign ready     = ready_q;

`ifdef FB_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum_c;

    // Refused requests and out-of-range pops can land on the same cycle, so add both then saturate.
    always_comb begin
        drop_sum_c = {1'b0, drop_cnt_q} + 17'(wr_req && wr_full_q) + 17'(oor_c);
        drop_cnt_d = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
